// File: rtl/wide_add_sequencer_pkg.sv
// rtl/wide_add_sequencer_pkg.sv - shared constants, FSM encoding and index-width helper
package wide_add_sequencer_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the slice index; never less than one bit.
  function automatic int clog2(input int words);
    int w;
    w = 0;
    while ((1 << w) < words) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/onesixbit.sv
// rtl/onesixbit.sv - 16-bit carry-lookahead adder built from four 4-bit groups
module onesixbit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        cout,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  // Group generate/propagate, lookahead across groups, then carries inside each group.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gg = '0;
    gp = '0;
    gc = '0;
    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j]   | (p[4*j]   & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    sum  = p ^ c;
    cout = gc[4];
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-precision add/sub, one 16-bit slice per cycle
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                    cin,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                    cout,
  output logic                    ovf,
  output logic                    busy
);

  localparam int N  = WORD_W * WORDS;
  localparam int IW = clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t          state;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic            carry;
  logic            a_msb;
  logic            b_msb;
  logic [IW-1:0]   idx;
  logic [WORD_W-1:0] a_slice;
  logic [WORD_W-1:0] b_slice;
  logic [WORD_W-1:0] s_sum;
  logic            s_cout;

  // Select the current slice of the captured operands for the shared adder.
  always_comb begin
    a_slice = a_reg[WORD_W*int'(idx) +: WORD_W];
    b_slice = b_reg[WORD_W*int'(idx) +: WORD_W];
  end

  onesixbit u_add (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry),
    .cout (s_cout),
    .sum  (s_sum)
  );

  // Control FSM with operand capture, carry chaining and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= sub ? ~b : b;
            carry    <= sub | cin;
            a_msb    <= a[N-1];
            b_msb    <= sub ? ~b[N-1] : b[N-1];
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum[WORD_W*int'(idx) +: WORD_W] <= s_sum;
          carry <= s_cout;
          if (idx == LAST) begin
            cout      <= s_cout;
            ovf       <= (a_msb ~^ b_msb) & (s_sum[WORD_W-1] ^ a_msb);
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - self-checking bench for wide_add_sequencer (WORDS=4)
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  wide_add_sequencer #(.WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned arithmetic on the whole operands.
  task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic mc, input logic ms,
                       output logic [63:0] es, output logic ec, output logic eo);
    logic signed [64:0] r;
    logic [64:0]        u;
    if (ms) begin
      r  = $signed({ma[63], ma}) - $signed({mb[63], mb});
      es = ma - mb;
      ec = (ma >= mb);
    end else begin
      r  = $signed({ma[63], ma}) + $signed({mb[63], mb}) + $signed({64'd0, mc});
      u  = {1'b0, ma} + {1'b0, mb} + {64'd0, mc};
      es = u[63:0];
      ec = u[64];
    end
    eo = (r[64] != r[63]);
  endtask

  task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic tc, input logic ts, input int hold, input bit full);
    logic [63:0] es;
    logic        ec;
    logic        eo;
    int          k;
    model(ta, tb_v, tc, ts, es, ec, eo);
    @(negedge clk);
    if (full) check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    k = 0;
    if (full) check({tag, ".busy"}, 64'(busy), 64'd1);
    while (!out_valid && k < 20) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    if (full) check({tag, ".latency"}, 64'(k), 64'd4);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, 64'(cout), 64'(ec));
    check({tag, ".ovf"}, 64'(ovf), 64'(eo));
    for (int h = 0; h < hold; h++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; in_valid = 1'($urandom);
      @(negedge clk);
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, ".hold_sum"}, sum, es);
      check({tag, ".hold_flags"}, {62'd0, cout, ovf}, {62'd0, ec, eo});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".done_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".done_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".retain_sum"}, sum, es);
  endtask

  initial begin
    #12;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.sum", sum, 64'd0);
    check("reset.flags", {62'd0, cout, ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("t1_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b1);
    run_op("t2_carry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 0, 1'b1);
    check("t2.const_sum", sum, 64'h0001_0000_0001_0000);
    run_op("t3_sub_neg", 64'd5, 64'd7, 1'b1, 1'b1, 0, 1'b1);
    check("t3.const_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("t3_sub_pos", 64'd7, 64'd5, 1'b0, 1'b1, 0, 1'b1);
    check("t3b.const_sum", sum, 64'd2);
    run_op("t4_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b1);
    check("t4.const_ovf", 64'(ovf), 64'd1);
    run_op("t5_backpressure", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 3, 1'b1);

    // Reset during the second RUN cycle.
    @(negedge clk);
    a = 64'hAAAA_0000_5555_FFFF; b = 64'h1111_2222_3333_4444; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6.busy", 64'(busy), 64'd0);
    check("t6.out_valid", 64'(out_valid), 64'd0);
    check("t6.sum", sum, 64'd0);
    check("t6.in_ready", 64'(in_ready), 64'd1);
    check("t6.flags", {62'd0, cout, ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t6_after", 64'd1, 64'd1, 1'b1, 1'b0, 0, 1'b1);
    check("t6.const_sum", sum, 64'd3);

    for (int i = 0; i < 24; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 6 == 0) rb = ~ra;
      if (i % 6 == 1) rb = ra;
      run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-precision add/subtract sequencer that time-shares one 16-bit carry-lookahead adder (`onesixbit`) to produce a WORDS×16-bit result. It processes one 16-bit slice per cycle, least-significant first, and chains the slice carry through a register. Operands enter and results leave over valid/ready handshakes. The block sits between the operand source and the result consumer, and it is the only driver of its `onesixbit` instance.

## Interface
- `WORDS`, default 4: number of 16-bit slices. Legal range is 2–16; operand width N = 16·WORDS.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: operand set present.
- `in_ready` output, 1: block can accept operands.
- `a` input, N: operand A.
- `b` input, N: operand B.
- `cin` input, 1: carry-in for add. Ignored when `sub`=1.
- `sub` input, 1: 0 selects A+B+cin; 1 selects A−B, computed as A+~B+1.
- `out_valid` output, 1: result valid.
- `out_ready` input, 1: consumer accepts the result.
- `sum` output, N: result.
- `cout` output, 1: carry out of the MSB. For subtract, 1 means no borrow.
- `ovf` output, 1: two's-complement signed overflow.
- `busy` output, 1: high while in RUN.

## Operation
- The FSM has three states.
  - IDLE: `in_ready`=1. When `in_valid`&&`in_ready`, the block captures `a`, ~`b` if `sub` else `b`, carry = `sub` ? 1 : `cin`, the operand MSBs, sets slice index 0, and goes to RUN.
  - RUN: each cycle it drives slice k of the captured A/B and the carry register into `onesixbit`. It writes the slice sum into `sum[16k+:16]` and the adder cout into the carry register, then increments k. At k = WORDS−1 it goes to DONE.
  - DONE: `out_valid`=1. On `out_ready` it returns to IDLE.
- `cout` is the final carry register value. `ovf` = (a_msb ~^ beff_msb) & (sum_msb ^ a_msb), where beff is the captured, possibly inverted, B.
- Inputs `a`, `b`, `cin`, `sub` are sampled only at acceptance. Later input changes have no effect.
- `sum`, `cout`, `ovf` hold stable from `out_valid` rising until the handshake completes, and retain their values after it.
- `in_ready` is 0 in RUN and DONE. `in_valid` asserted there is ignored, not queued.
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, `ovf`=0, slice index 0, carry 0.

## Timing
- Acceptance at edge T0. RUN occupies cycles T0+1 … T0+WORDS, one slice per cycle.
- `out_valid` rises at edge T0+WORDS, so latency is WORDS cycles.
- If `out_ready` is already high, `out_valid` lasts 1 cycle and `in_ready` rises at the next edge.
- Throughput is one operation per WORDS+2 cycles. There is no overlap of accept and deliver.
- The carry register is the only path between slices. The combinational path is one `onesixbit` evaluation plus the register mux.
- Reset asserted mid-RUN or mid-DONE: the block returns to IDLE immediately (asynchronous), drops partial results, and clears all outputs to their reset values. The first acceptance is possible on the first rising edge after release.
- Slice index wrap: the index never exceeds WORDS−1. The transition to DONE occurs on the same edge as the last slice write.

## Structure
- Shared package holds: `WORD_W`=16, the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and the slice-index width function clog2(WORDS).
- One sub-module: the existing `onesixbit` instance (ports a, b, cin, cout, sum), used unchanged.
- Slice multiplexing, carry register, result register and FSM live in `wide_add_sequencer`.

## Test plan
All scenarios use WORDS=4.
1. A=64'hFFFF_FFFF_FFFF_FFFF, B=1, cin=0, sub=0 → sum=0, cout=1, ovf=0; `out_valid` exactly 4 cycles after accept.
2. A=64'h0000_FFFF_0000_FFFF, B=64'h0000_0001_0000_0001, cin=0 → sum=64'h0001_0000_0001_0000, cout=0. Checks that carry crosses slices.
3. Subtract: A=5, B=7, sub=1 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then A=7, B=5 → sum=2, cout=1.
4. Signed overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, sub=0 → sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
5. Backpressure: hold `out_ready`=0 for 3 cycles after `out_valid`, toggling `a`/`b`/`in_valid` → `sum`/`cout`/`ovf` stable, `in_ready`=0, no extra transaction. Accept on cycle 4, then `in_ready`=1 next cycle.
6. Reset mid-operation: assert `rst_n`=0 during the second RUN cycle → `busy`, `out_valid`, `sum` clear immediately. After release, a new A=1, B=1, cin=1 yields sum=3 after 4 cycles.
